inertial_integrator: RTL
========================

INERTIAL_INTEGRATOR -- requirements
Module: inertial_integrator

Interface
REQ-001 clk  input  1  system clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 vld  input  1  new inertial sample strobe, one cycle wide; may be asserted on consecutive cycles.
REQ-004 ptch_rt_raw  input  16  signed raw pitch-rate gyro sample, valid when vld=1.
REQ-005 AZ  input  16  signed raw Z-accelerometer sample, valid when vld=1.
REQ-006 recal  input  1  pulse that restarts gyro offset calibration.
REQ-007 ptch  output  16  signed fused pitch to the balance controller.
REQ-008 ptch_rt  output  16  signed offset-compensated pitch rate to the balance controller.
REQ-009 ptch_vld  output  1  one-cycle strobe; ptch and ptch_rt are updated.
REQ-010 cal_done  output  1  high while in RUN.

Function
REQ-011 States: CAL and RUN; the block shall leave reset in CAL.
REQ-012 CAL: on each vld, the block shall add sign-extended ptch_rt_raw into a 20-bit signed accumulator and increment a 4-bit sample counter.
REQ-013 CAL exit: on the 16th vld, the block shall latch offset = (accumulator + sample) >>> 4 (arithmetic, floor), go to RUN and set cal_done on the next cycle.
REQ-014 In CAL, ptch_vld shall stay 0; ptch and ptch_rt shall hold 0.
REQ-015 RUN, on each vld, ptch_rt shall register ptch_rt_raw - offset, computed in 17 bits and saturated to 0x7FFF/0x8000.
REQ-016 RUN, on each vld, az_comp shall be AZ - AZ_OFFSET (0x00A0), computed in 17 bits.
REQ-017 RUN, on each vld, ptch_acc shall be bits [25:13] of az_comp*PTCH_SCALE (327, signed), sign-extended to 16 bits.
REQ-018 RUN, on each vld, fusion shall be +FUSION_STEP (1024) when ptch_acc > the currently registered ptch (signed compare), else -FUSION_STEP.
REQ-019 RUN, on each vld, the 27-bit signed integrator shall update as ptch_int <= ptch_int - ptch_rt_comp + fusion, where ptch_rt_comp is the saturated value of REQ-015 from the same sample.
REQ-020 RUN, on each vld, the integrator shall wrap without saturation.
REQ-021 RUN, on each vld, ptch shall register ptch_int_next[26:11].
REQ-022 ptch_vld shall assert exactly one cycle after each RUN vld, coincident with the updated ptch and ptch_rt; latency is 1 cycle.
REQ-023 Outputs shall hold between vld strobes.
REQ-024 recal=1 shall force CAL and clear the accumulator, counter, integrator, ptch, ptch_rt, ptch_vld and cal_done on the next edge.
REQ-025 recal=1 and vld=1 in the same cycle: recal wins and the sample shall be discarded.
REQ-026 recal=1 during CAL shall restart counting from 0.
REQ-027 The offset register shall hold its value until the next CAL exit.

Reset
REQ-028 While rst_n=0 at a clock edge, the block shall set state=CAL, accumulator=0, counter=0, offset=0, ptch_int=0, ptch=0, ptch_rt=0, ptch_vld=0 and cal_done=0.
REQ-029 Reset shall take priority over recal and vld.
REQ-030 Reset asserted mid-calibration or mid-RUN shall discard all progress.

Structure
REQ-031 Package inert_pkg shall hold the state enum (CAL, RUN) and the constants AZ_OFFSET, PTCH_SCALE, FUSION_STEP and CAL_SAMPLES (16).
REQ-032 One sub-module, gyro_offset_cal, shall hold the accumulator, the counter and offset latching; its outputs shall be offset and cal_done.
REQ-033 The top level shall hold compensation, fusion, the integrator and the output registers.

Verification
REQ-034 Reset: rst_n=0 for 2 cycles with vld toggling -> ptch=0, ptch_rt=0, ptch_vld=0, cal_done=0.
REQ-035 Calibration: 16 vld with raw=0x0010 -> cal_done=1 one cycle after the 16th vld; a following raw=0x0010 gives ptch_rt=0x0000.
REQ-036 Negative offset: 16 samples alternating -3/-4 (sum -56) -> offset=-4; raw=0x7FFF then gives ptch_rt=0x7FFF (saturated).
REQ-037 Integration with offset=0, AZ=0x00A0, raw=0x0800: 1st vld -> ptch_int=-3072, ptch=0xFFFE, ptch_vld pulses once.
REQ-038 Integration, continued: 2nd vld -> ptch_acc=0 > ptch=-2, so ptch_int=-4096 and ptch=0xFFFE.
REQ-039 recal together with vld in RUN -> next cycle cal_done=0, ptch=0, ptch_vld=0; 16 further vld are required before cal_done=1.

Source files
------------

// File: rtl/inert_pkg.sv
// inert_pkg: shared states and constants for the inertial pitch integrator.
//   CAL/RUN state encoding, accelerometer offset, pitch scale, fusion step
//   and the number of samples averaged for the gyro offset.
package inert_pkg;

    typedef enum logic {CAL, RUN} state_e;

    localparam logic signed [16:0] AZ_OFFSET   = 17'sh000A0;
    localparam logic signed [10:0] PTCH_SCALE  = 11'sd327;
    localparam logic signed [26:0] FUSION_STEP = 27'sd1024;
    localparam int                 CAL_SAMPLES = 16;

endpackage

// File: rtl/gyro_offset_cal.sv
// gyro_offset_cal: averages the first 16 gyro samples after reset/recal into an offset.
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   vld_i      sample strobe
//   recal_i    restart calibration (offset keeps its old value until the next exit)
//   raw_i      signed raw pitch-rate sample
//   offset_o   latched gyro offset
//   cal_done_o high while in RUN
module gyro_offset_cal
    import inert_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld_i,
    input  logic        recal_i,
    input  logic [15:0] raw_i,
    output logic [15:0] offset_o,
    output logic        cal_done_o
);

    state_e             state_q, state_d;
    logic signed [19:0] acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [15:0]        offset_q, offset_d;
    logic signed [19:0] sum;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        sum      = acc_q + {{4{raw_i[15]}}, raw_i};
        if (recal_i) begin
            state_d = CAL;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == CAL && vld_i) begin
            if (cnt_q == 4'(CAL_SAMPLES - 1)) begin
                // The last sample is folded in combinationally; >>> floors the average.
                offset_d = 16'(sum >>> 4);
                state_d  = RUN;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= CAL;
            acc_q    <= '0;
            cnt_q    <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
        end
    end

    assign offset_o   = offset_q;
    assign cal_done_o = (state_q == RUN);

endmodule

// File: rtl/inertial_integrator.sv
// inertial_integrator: fuses offset-compensated gyro rate with accelerometer pitch.
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   vld          inertial sample strobe
//   ptch_rt_raw  signed raw pitch-rate sample
//   AZ           signed raw Z-accelerometer sample
//   recal        restart gyro offset calibration
//   ptch         signed fused pitch
//   ptch_rt      signed compensated pitch rate
//   ptch_vld     one-cycle strobe, ptch/ptch_rt updated
//   cal_done     high while running
module inertial_integrator
    import inert_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic [15:0] ptch_rt_raw,
    input  logic [15:0] AZ,
    input  logic        recal,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt,
    output logic        ptch_vld,
    output logic        cal_done
);

    logic [15:0]        offset;
    logic               upd;
    logic signed [16:0] rt_diff;
    logic signed [15:0] rt_sat;
    logic signed [16:0] az_comp;
    logic signed [26:0] az_ext;
    logic signed [26:0] prod;
    logic signed [15:0] ptch_acc;
    logic signed [26:0] fusion;
    logic signed [26:0] ptch_int_q, ptch_int_d;
    logic signed [15:0] ptch_q, ptch_d;
    logic signed [15:0] ptch_rt_q, ptch_rt_d;
    logic               ptch_vld_q;
    logic               unused_prod;

    gyro_offset_cal u_cal (
        .clk        (clk),
        .rst_n      (rst_n),
        .vld_i      (vld),
        .recal_i    (recal),
        .raw_i      (ptch_rt_raw),
        .offset_o   (offset),
        .cal_done_o (cal_done)
    );

    // recal wins over a coincident sample, which is then dropped.
    assign upd     = vld && cal_done && !recal;
    assign rt_diff = {ptch_rt_raw[15], ptch_rt_raw} - {offset[15], offset};
    assign rt_sat  = (rt_diff > 17'sd32767)  ? 16'sh7FFF :
                     (rt_diff < -17'sd32768) ? 16'sh8000 : rt_diff[15:0];

    // Accelerometer pitch: scaled Z acceleration, bits [25:13] of the product.
    assign az_comp     = {AZ[15], AZ} - AZ_OFFSET;
    assign az_ext      = 27'(az_comp);
    assign prod        = az_ext * 27'(PTCH_SCALE);
    assign ptch_acc    = {{3{prod[25]}}, prod[25:13]};
    assign unused_prod = ^{prod[26], prod[12:0]};

    // Complementary filter: nudge the integrated pitch toward the accelerometer.
    assign fusion     = (ptch_acc > ptch_q) ? FUSION_STEP : -FUSION_STEP;
    assign ptch_int_d = ptch_int_q - {{11{rt_sat[15]}}, rt_sat} + fusion;
    assign ptch_d     = ptch_int_d[26:11];
    assign ptch_rt_d  = rt_sat;

    always_ff @(posedge clk) begin
        if (!rst_n || recal) begin
            ptch_int_q <= '0;
            ptch_q     <= '0;
            ptch_rt_q  <= '0;
            ptch_vld_q <= 1'b0;
        end else begin
            ptch_vld_q <= upd;
            if (upd) begin
                ptch_int_q <= ptch_int_d;
                ptch_q     <= ptch_d;
                ptch_rt_q  <= ptch_rt_d;
            end
        end
    end

    assign ptch     = ptch_q;
    assign ptch_rt  = ptch_rt_q;
    assign ptch_vld = ptch_vld_q;

endmodule
